// File: rtl/rll_seq_key_unit_if.sv
// Key-provisioning handshake and locked datapath bundle for rll_seq_key_unit.
// master drives key/data requests; slave (the unit) returns status and gated data.
interface rll_seq_key_unit_if #(
  parameter int DATA_W = 32
) ();
  logic              key_start;
  logic              key_valid;
  logic              key_bit;
  logic              key_ready;
  logic              armed;
  logic              key_err;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              dout_valid;
  logic [DATA_W-1:0] dout;

  modport master (
    output key_start, key_valid, key_bit, din_valid, din,
    input  key_ready, armed, key_err, dout_valid, dout
  );

  modport slave (
    input  key_start, key_valid, key_bit, din_valid, din,
    output key_ready, armed, key_err, dout_valid, dout
  );
endinterface

// File: rtl/rll_seq_key_unit.sv
// Serial-load XOR key-gate lock: 1-cycle datapath, key bits accepted while key_ready is high.
// Optional RLL_KEY_PARITY_EN adds a trailing even-parity bit check with a sticky key_err.
module rll_seq_key_unit #(
  parameter int               KEY_W   = 32,
  parameter int               DATA_W  = 32,
  parameter logic [KEY_W-1:0] KEY_POL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  rll_seq_key_unit_if.slave    bus
);

  localparam int CW = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef RLL_KEY_PARITY_EN
    PAR,
`endif
    ARMED,
    ERR
  } state_t;

  state_t            state_q;
  logic [KEY_W-1:0]  key_q;
  logic [CW-1:0]     cnt_q;
  logic              key_ready_q;
  logic              armed_q;
  logic              key_err_q;
  logic [KEY_W-1:0]  ek;
  logic [DATA_W-1:0] mask_d;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      armed_q     <= 1'b0;
      key_err_q   <= 1'b0;
    end else if (bus.key_start) begin
      // key_start wins over any key bit offered in the same cycle
      state_q     <= LOAD;
      key_q       <= '0;
      cnt_q       <= '0;
      key_ready_q <= 1'b1;
      armed_q     <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.key_valid && key_ready_q) begin
            for (int i = 0; i < KEY_W; i++) begin
              if (cnt_q == CW'(i)) key_q[i] <= bus.key_bit;
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(KEY_W - 1)) begin
`ifdef RLL_KEY_PARITY_EN
              state_q     <= PAR;
`else
              state_q     <= ARMED;
              key_ready_q <= 1'b0;
              armed_q     <= 1'b1;
`endif
            end
          end
        end
`ifdef RLL_KEY_PARITY_EN
        PAR: begin
          if (bus.key_valid && key_ready_q) begin
            key_ready_q <= 1'b0;
            if (bus.key_bit == ^key_q) begin
              state_q <= ARMED;
              armed_q <= 1'b1;
            end else begin
              state_q   <= ERR;
              key_q     <= '0;
              key_err_q <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Only a completed, accepted key reaches the gates; anything else looks like all-zero.
  assign ek = (state_q == ARMED) ? key_q : '0;

  always_comb begin
    mask_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask_d[i] = ek[i % KEY_W] ^ KEY_POL[i % KEY_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= bus.din_valid;
      if (bus.din_valid) dout_q <= bus.din ^ mask_d;
    end
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.armed      = armed_q;
`ifdef RLL_KEY_PARITY_EN
  assign bus.key_err    = key_err_q;
`else
  assign bus.key_err    = 1'b0;
`endif
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_rll_seq_key_unit.sv
// Directed bench for rll_seq_key_unit (KEY_W=4, DATA_W=8, KEY_POL=4'b1010) with a data scoreboard.
module tb_rll_seq_key_unit;
  localparam logic [3:0] POL = 4'b1010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  rll_seq_key_unit_if #(.DATA_W(8)) bus ();

  rll_seq_key_unit #(.KEY_W(4), .DATA_W(8), .KEY_POL(POL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] gate(input logic [7:0] d, input logic [3:0] ek);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[i] ^ ek[i % 4] ^ POL[i % 4];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; if data was presented, compare against the scoreboard head.
  task automatic tick();
    logic sent;
    logic [7:0] e;
    sent = bus.din_valid;
    @(posedge clk);
    #1;
    if (sent) begin
      chk("dout_valid", {7'd0, bus.dout_valid}, 8'd1);
      if (sb.size() == 0) chk("sb_underflow", 8'd1, 8'd0);
      else begin
        e = sb.pop_front();
        chk("dout", bus.dout, e);
      end
    end
  endtask

  task automatic data(input logic [7:0] d, input logic [7:0] exp);
    bus.din = d; bus.din_valid = 1'b1; sb.push_back(exp);
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic kstart();
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
  endtask

  task automatic kbit(input logic b);
    bus.key_valid = 1'b1; bus.key_bit = b;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic load4(input logic [3:0] k);
    for (int i = 0; i < 4; i++) kbit(k[i]);
`ifdef RLL_KEY_PARITY_EN
    kbit(^k);
`endif
  endtask

  initial begin
    logic [7:0] hold;
    bus.key_start = 0; bus.key_valid = 0; bus.key_bit = 0;
    bus.din_valid = 0; bus.din = 8'h00;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_key_ready", {7'd0, bus.key_ready}, 8'd0);
    chk("rst_armed", {7'd0, bus.armed}, 8'd0);
    chk("rst_key_err", {7'd0, bus.key_err}, 8'd0);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_dout_valid", {7'd0, bus.dout_valid}, 8'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // no key loaded
    data(8'hA5, 8'h0F);
    chk("nokey_armed", {7'd0, bus.armed}, 8'd0);
    data(8'h3C, gate(8'h3C, 4'b0000));

    // correct key 0,1,0,1; data on the final-bit edge still sees the zero key
    kstart();
    chk("load_key_ready", {7'd0, bus.key_ready}, 8'd1);
    kbit(1'b0); kbit(1'b1); kbit(1'b0);
    chk("partial_armed", {7'd0, bus.armed}, 8'd0);
`ifdef RLL_KEY_PARITY_EN
    kbit(1'b1);
    bus.key_valid = 1'b1; bus.key_bit = 1'b0;
`else
    bus.key_valid = 1'b1; bus.key_bit = 1'b1;
`endif
    bus.din = 8'hA5; bus.din_valid = 1'b1; sb.push_back(8'h0F);
    tick();
    bus.key_valid = 1'b0; bus.din_valid = 1'b0;
    chk("good_armed", {7'd0, bus.armed}, 8'd1);
    chk("armed_key_ready", {7'd0, bus.key_ready}, 8'd0);
    data(8'hA5, 8'hA5);
    data(8'h3C, 8'h3C);
    kbit(1'b1);
    data(8'h5A, 8'h5A);

    // hold when din_valid low
    hold = bus.dout;
    tick(); tick();
    chk("hold_dout", bus.dout, hold);
    chk("idle_dout_valid", {7'd0, bus.dout_valid}, 8'd0);

    // key_start while armed drops armed next edge
    kstart();
    chk("restart_armed", {7'd0, bus.armed}, 8'd0);
    data(8'hA5, 8'h0F);

    // wrong key 0,0,0,0
    load4(4'b0000);
    chk("wrong_armed", {7'd0, bus.armed}, 8'd1);
    data(8'hA5, 8'h0F);
    data(8'hFF, gate(8'hFF, 4'b0000));

`ifdef RLL_KEY_PARITY_EN
    kstart();
    kbit(1'b0); kbit(1'b1); kbit(1'b0); kbit(1'b1); kbit(1'b1);
    chk("par_key_err", {7'd0, bus.key_err}, 8'd1);
    chk("par_armed", {7'd0, bus.armed}, 8'd0);
    data(8'hA5, 8'h0F);
    kstart();
    chk("par_clear_err", {7'd0, bus.key_err}, 8'd0);
    load4(4'b1010);
    chk("par_rearm", {7'd0, bus.armed}, 8'd1);
    chk("par_err_low", {7'd0, bus.key_err}, 8'd0);
`endif

    // gaps between bits 2 and 3
    kstart();
    kbit(1'b0); kbit(1'b1); kbit(1'b0);
    tick(); tick(); tick();
    chk("gap_armed", {7'd0, bus.armed}, 8'd0);
    kbit(1'b1);
`ifdef RLL_KEY_PARITY_EN
    kbit(1'b0);
`endif
    chk("gap_armed_after", {7'd0, bus.armed}, 8'd1);
    data(8'hA5, 8'hA5);

    // key_start colliding with key_valid: bit dropped, count restarts
    kstart();
    kbit(1'b1); kbit(1'b1);
    bus.key_start = 1'b1; bus.key_valid = 1'b1; bus.key_bit = 1'b1;
    tick();
    bus.key_start = 1'b0; bus.key_valid = 1'b0;
    kbit(1'b0); kbit(1'b1); kbit(1'b0);
    chk("collide_not_armed", {7'd0, bus.armed}, 8'd0);
    kbit(1'b1);
`ifdef RLL_KEY_PARITY_EN
    kbit(1'b0);
`endif
    chk("collide_armed", {7'd0, bus.armed}, 8'd1);
    data(8'hA5, 8'hA5);

    // async reset while armed, mid-stream
    bus.din = 8'hC3; bus.din_valid = 1'b1; sb.push_back(8'hC3);
    tick();
    bus.din = 8'h7E; sb.push_back(8'h7E);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", bus.dout, 8'h00);
    chk("arst_dout_valid", {7'd0, bus.dout_valid}, 8'd0);
    chk("arst_armed", {7'd0, bus.armed}, 8'd0);
    chk("arst_key_ready", {7'd0, bus.key_ready}, 8'd0);
    bus.din_valid = 1'b0;
    sb.delete();
    #3 rst = 1'b0;
    @(posedge clk); #1;
    data(8'hA5, 8'h0F);
    chk("sb_empty", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rll_seq_key_unit.md
# rll_seq_key_unit

Parametrised, sequential successor to the fixed 32-bit random-logic-locking (RLL) key-gate layer. It loads a KEY_W-bit key serially through a valid/ready handshake and holds it in a key register. It then applies XOR key gates, with per-bit polarity, to a registered DATA_W-bit datapath. It sits between the chip's key-provisioning port and a locked datapath: only the correct key makes the datapath output equal its input.

## Interface
- KEY_W, 32: key length in bits, ≥2.
- DATA_W, 32: datapath width; data bit i is gated by key bit i % KEY_W.
- KEY_POL, {KEY_W{1'b0}}: correct-key pattern. Key bit i is cancelled when key[i] == KEY_POL[i].
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_start  in  1  pulse: clear the key and begin a load.
- key_valid  in  1  key bit offered.
- key_bit  in  1  key bit value.
- key_ready  out  1  high while the unit accepts key bits.
- armed  out  1  a full key has been loaded and accepted.
- key_err  out  1  parity failure; sticky until the next key_start or reset (RLL_KEY_PARITY_EN only, tied 0 otherwise).
- din_valid  in  1  input data valid.
- din  in  DATA_W  input data.
- dout_valid  out  1  registered copy of din_valid.
- dout  out  DATA_W  gated, registered data.

## Operation
- States: IDLE, LOAD, PAR (only with RLL_KEY_PARITY_EN), ARMED, ERR.
- Reset: state IDLE, key register = 0, bit counter = 0, key_ready=0, armed=0, key_err=0, dout=0, dout_valid=0.
- key_start in any state:
  - next state LOAD; key register and counter cleared; armed and key_err cleared.
  - A key_valid in the same cycle is ignored.
- LOAD:
  - key_ready=1.
  - Each cycle with key_valid && key_ready writes key[cnt] = key_bit and increments cnt. The first bit accepted is key[0].
  - The bit that brings cnt to KEY_W exits to PAR if the macro is defined, otherwise to ARMED. cnt is $clog2(KEY_W+1) bits and never wraps.
- PAR:
  - key_ready=1.
  - The next accepted bit is compared with the XOR-reduction of the key register.
  - Match goes to ARMED. Mismatch goes to ERR and clears the key register.
- ARMED: key_ready=0, armed=1. Further key_valid is ignored.
- ERR: key_ready=0, key_err=1, armed=0.
- IDLE: key_ready=0. key_valid is ignored.
- Gating:
  - Effective key ek = key register in ARMED, all-zero otherwise.
  - dout[i] <= din[i] ^ ek[i%KEY_W] ^ KEY_POL[i%KEY_W].
  - A wrong, partial or absent key therefore corrupts dout.
- dout updates only when din_valid=1 and holds otherwise. dout_valid follows din_valid every cycle.

## Timing
- Datapath latency: 1 cycle from din to dout and from din_valid to dout_valid. Fully pipelined, one word per cycle.
- Key load takes KEY_W accepted handshakes (KEY_W+1 with parity).
- armed rises on the cycle after the final accepted bit. Data sampled in that same edge's cycle still uses the zero key.
- key_start while ARMED: armed drops on the next edge, and the zero key applies to din from that cycle on.
- Asynchronous reset mid-load: all state clears immediately. The partial key is discarded.

## Configuration
- RLL_KEY_PARITY_EN:
  - Defined: the PAR state and key_err exist. One trailing even-parity bit is required after the key, and a mismatch locks in ERR until key_start.
  - Undefined: there is no PAR state, key_err is tied 0, and the unit arms directly after KEY_W bits.

## Test plan
All scenarios use KEY_W=4, DATA_W=8, KEY_POL=4'b1010.
- Reset, then din=8'hA5, din_valid=1 with no key loaded -> dout=8'h0F one cycle later; armed=0.
- key_start, then bits 0,1,0,1 (plus parity 0 if the macro is defined) -> armed=1. din=8'hA5 -> dout=8'hA5; din=8'h3C -> dout=8'h3C.
- Load wrong key bits 0,0,0,0 (parity 0) -> armed=1. din=8'hA5 -> dout=8'h0F.
- Parity build: load 0,1,0,1 then parity 1 -> key_err=1, armed=0, dout for 8'hA5 = 8'h0F. key_start then a correct load -> key_err=0, armed=1.
- Deassert key_valid for 3 cycles between bits 2 and 3, and assert key_start together with key_valid mid-load -> gaps are tolerated; the colliding bit is dropped; the counter restarts at 0.
- Assert rst asynchronously while ARMED, mid-stream -> dout=0, dout_valid=0, armed=0 immediately, without waiting for a clock edge.
